// File: rtl/fibo_pkg.sv
// Shared types and seed constants for the Fibonacci/Lucas term engine.
package fibo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FIB_SEED0 = 0;
    localparam int unsigned FIB_SEED1 = 1;
    localparam int unsigned LUC_SEED0 = 2;
    localparam int unsigned LUC_SEED1 = 1;

endpackage

// File: rtl/fibo_step.sv
// One recurrence step: next term = a + b, with a sticky overflow flag that
// also inherits any overflow already carried by either operand.
module fibo_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_ovf,
    input  logic              b_ovf,
    output logic [DATA_W-1:0] sum,
    output logic              sum_ovf
);

    logic carry;

    assign {carry, sum} = {1'b0, a} + {1'b0, b};
    assign sum_ovf      = carry | a_ovf | b_ovf;

endmodule

// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci/Lucas term generator: IDLE -> CALC (n steps) -> DONE,
// with saturation to all-ones when the returned term no longer fits DATA_W.
module fibonacci_engine
    import fibo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [IDX_W-1:0]  index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  count;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              a_ovf;
    logic              b_ovf;
    logic [DATA_W-1:0] sum;
    logic              sum_ovf;

    fibo_step #(.DATA_W(DATA_W)) u_step (
        .a       (a),
        .b       (b),
        .a_ovf   (a_ovf),
        .b_ovf   (b_ovf),
        .sum     (sum),
        .sum_ovf (sum_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // The a term lags b by one step, so an overflow seen only in b is
    // reported solely if another step promotes it into a.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            a        <= '0;
            b        <= '0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so a<=b and b<=a+b both use pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= index;
                        a     <= mode ? DATA_W'(LUC_SEED0) : DATA_W'(FIB_SEED0);
                        b     <= mode ? DATA_W'(LUC_SEED1) : DATA_W'(FIB_SEED1);
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        a     <= b;
                        b     <= sum;
                        a_ovf <= b_ovf;
                        b_ovf <= sum_ovf;
                        count <= count - 1'b1;
                    end else begin
                        result   <= a_ovf ? '1 : a;
                        overflow <= a_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
